// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_filter block.
// Provides clog2 (minimum result 1), the minimum legal STAGES/FILTER values
// and a parameter-range check used at elaboration by the top level.
package sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned SYNC_MIN_FILTER = 1;

  // Ceiling log2; never returns less than 1 so counters keep at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // True when the channel count, chain depth and filter length are legal.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned stages,
                                   input int unsigned filter);
    return (width >= 1) && (stages >= SYNC_MIN_STAGES) && (filter >= SYNC_MIN_FILTER);
  endfunction

endpackage

// File: rtl/sync_filter_if.sv
// Boundary bundle for sync_filter.
//   async_in : raw asynchronous inputs
//   sync_out : filtered, synchronised levels
//   rise     : one-clock pulse per bit on a 0->1 change of sync_out
//   fall     : one-clock pulse per bit on a 1->0 change of sync_out
// master drives async_in (the pad side); slave is the filter.
interface sync_filter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output async_in, input sync_out, input rise, input fall);
  modport slave  (input async_in, output sync_out, output rise, output fall);
endinterface

// File: rtl/sync_filter_chan.sv
// One channel of sync_filter: STAGES-deep synchroniser chain followed by a
// stability filter that accepts a new level only after it has persisted for
// FILTER consecutive clocks, with registered rise/fall pulses.
//   clk, rst (sync, active low), din (async input),
//   sync_out / rise / fall (registered outputs).
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILTER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = clog2(FILTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic [STAGES-1:0] stage_q, stage_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              s;

  assign s = stage_q[STAGES-1];

  // Next state: shift the chain, then count how long s has disagreed with out.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], din};
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d  = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync_out = out_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input synchroniser with glitch filter and edge detection.
//   clk      : clock
//   rst      : synchronous active-low reset
//   bus      : sync_filter_if.slave (async_in in; sync_out, rise, fall out)
// Default build: WIDTH independent per-bit filters (sync_filter_chan).
// With SYNC_FILTER_WORD_EN defined: word-coherent mode, one shared counter
// that restarts whenever any synchronised bit moves, so the whole word is
// accepted in a single clock.
module sync_filter
  import sync_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILTER = 4
) (
  input logic          clk,
  input logic          rst,
  sync_filter_if.slave bus
);

  if (!params_ok(WIDTH, STAGES, FILTER)) begin : g_bad_params
    $error("sync_filter: WIDTH>=1, STAGES>=2, FILTER>=1 required");
  end

`ifdef SYNC_FILTER_WORD_EN

  localparam int unsigned CW = clog2(FILTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_prev_q, s_prev_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Per-bit synchroniser chains.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    logic [STAGES-1:0] chain_q, chain_d;
    always_comb chain_d = {chain_q[STAGES-2:0], bus.async_in[gi]};
    always_ff @(posedge clk) begin
      if (!rst) chain_q <= '0;
      else      chain_q <= chain_d;
    end
    assign s[gi] = chain_q[STAGES-1];
  end

  // Shared filter: count only while the word is both stable and different.
  always_comb begin
    s_prev_d = s;
    cnt_d    = cnt_q;
    out_d    = out_q;
    rise_d   = '0;
    fall_d   = '0;
    if (s != s_prev_q) begin
      cnt_d = '0;
    end else if (s != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d  = s;
        cnt_d  = '0;
        rise_d = s & ~out_q;
        fall_d = ~s & out_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_prev_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      s_prev_q <= s_prev_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign bus.sync_out = out_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;

`else

  logic [WIDTH-1:0] out_w, rise_w, fall_w;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    sync_filter_chan #(
      .STAGES (STAGES),
      .FILTER (FILTER)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .din      (bus.async_in[gi]),
      .sync_out (out_w[gi]),
      .rise     (rise_w[gi]),
      .fall     (fall_w[gi])
    );
  end

  assign bus.sync_out = out_w;
  assign bus.rise     = rise_w;
  assign bus.fall     = fall_w;

`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter with WIDTH=4, STAGES=2, FILTER=3.
// Each vector row drives rst/async_in for n clocks and checks the outputs
// after every one of those edges; a change sampled at an edge reaches
// sync_out on the fourth edge after it.
module tb_sync_filter;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sync_filter_if #(.WIDTH(W)) bus ();

  sync_filter #(
    .WIDTH  (W),
    .STAGES (2),
    .FILTER (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic        r;
    logic [W-1:0] din;
    logic [W-1:0] e_out;
    logic [W-1:0] e_rise;
    logic [W-1:0] e_fall;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one clock of stimulus, then check all outputs just after the edge.
  task automatic step(input logic r, input logic [W-1:0] d,
                      input logic [W-1:0] eo, input logic [W-1:0] er,
                      input logic [W-1:0] ef, input string tag);
    rst          = r;
    bus.async_in = d;
    @(posedge clk);
    #1;
    check({tag, " sync_out"}, bus.sync_out, eo);
    check({tag, " rise"}, bus.rise, er);
    check({tag, " fall"}, bus.fall, ef);
    check({tag, " rise&fall"}, bus.rise & bus.fall, '0);
  endtask

  initial begin
    bus.async_in = '0;

    // reset held with inputs high, then release: rise after the 5th edge
    vecs.push_back('{3, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0});
    vecs.push_back('{1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0});
    // all inputs drop
    vecs.push_back('{4, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF});
    vecs.push_back('{1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0});
    // 2-clock glitch on bit0 is rejected
    vecs.push_back('{2, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{6, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0});
    // 3-clock pulse on bit0 is accepted, then its end is accepted too
    vecs.push_back('{3, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'h0, 4'h1, 4'h1, 4'h0});
    vecs.push_back('{2, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1});
    vecs.push_back('{2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0});
    // bits 2 and 3 rise
    vecs.push_back('{4, 1'b1, 4'hC, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'hC, 4'hC, 4'hC, 4'h0});
    vecs.push_back('{1, 1'b1, 4'hC, 4'hC, 4'h0, 4'h0});
    // bit2 falls alone
    vecs.push_back('{4, 1'b1, 4'h8, 4'hC, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'h8, 4'h8, 4'h0, 4'h4});
    vecs.push_back('{1, 1'b1, 4'h8, 4'h8, 4'h0, 4'h0});
    // bit1 rises and bit3 falls on the same edge
    vecs.push_back('{4, 1'b1, 4'h2, 4'h8, 4'h0, 4'h0});
    vecs.push_back('{1, 1'b1, 4'h2, 4'h2, 4'h2, 4'h8});
    vecs.push_back('{2, 1'b1, 4'h2, 4'h2, 4'h0, 4'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        step(vecs[i].r, vecs[i].din, vecs[i].e_out, vecs[i].e_rise, vecs[i].e_fall,
             $sformatf("vec%0d.%0d", i, k));
      end
    end

    // reset while bit0's counter sits at FILTER-1: partial count is discarded
    for (int k = 0; k < 4; k++) step(1'b1, 4'h3, 4'h2, 4'h0, 4'h0, $sformatf("midrst_pre%0d", k));
    step(1'b0, 4'h3, 4'h0, 4'h0, 4'h0, "midrst_in");
    for (int k = 0; k < 4; k++) step(1'b1, 4'h3, 4'h0, 4'h0, 4'h0, $sformatf("midrst_post%0d", k));
    step(1'b1, 4'h3, 4'h3, 4'h3, 4'h0, "midrst_accept");
    for (int k = 0; k < 3; k++) step(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, $sformatf("midrst_hold%0d", k));

    // glitch that returns after 1 clock, then a fresh change needs the full count
    step(1'b1, 4'h2, 4'h3, 4'h0, 4'h0, "restart_g");
    step(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, "restart_back");
    for (int k = 0; k < 4; k++) step(1'b1, 4'h2, 4'h3, 4'h0, 4'h0, $sformatf("restart_wait%0d", k));
    step(1'b1, 4'h2, 4'h2, 4'h0, 4'h1, "restart_accept");
    step(1'b1, 4'h2, 4'h2, 4'h0, 4'h0, "restart_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
